// File: rtl/terrain_scroller_if.sv
// ============================================================================
// Module      : terrain_scroller_if
// Description : Background tile RAM write port (valid/ready) of the terrain
//               scroller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface terrain_scroller_if #(
    parameter int ADDR_W = 16
) ();
    logic              bg_we;
    logic              bg_ready;
    logic [ADDR_W-1:0] bg_addr;
    logic [15:0]       bg_data;

    modport master (output bg_we, bg_addr, bg_data, input bg_ready);
    modport slave  (input bg_we, bg_addr, bg_data, output bg_ready);
endinterface

`default_nettype wire

// File: rtl/terrain_scroller.sv
// ============================================================================
// Module      : terrain_scroller
// Description : Scrolling ground band with speed-up and random gap spawning.
//               Optional HUD_LOCK_EN adds y_i / HUD_H and zeroes the scroll
//               offset for HUD rows.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module terrain_scroller #(
    parameter int TILE_COLS        = 40,
    parameter int TILE_ROWS        = 30,
    parameter int FLOOR_ROWS       = 3,
    parameter int GAP_W            = 2,
    parameter int GAP_START_COL    = 10,
    parameter int SCROLL_DELAY_MAX = 1000000,
    parameter int SCROLL_DELAY_MIN = 200000,
    parameter int SPEED_STEP       = 100000,
    parameter int SPEEDUP_COLS     = 64,
    parameter int WAIT_UNIT        = 500000,
    parameter int ADDR_W           = 16
`ifdef HUD_LOCK_EN
    , parameter int HUD_H          = 32
`endif
) (
    input  wire logic          clk,
    input  wire logic          reset,
    input  wire logic          enable_i,
`ifdef HUD_LOCK_EN
    input  wire logic [9:0]    y_i,
`endif
    terrain_scroller_if.master bg_if,
    output logic [3:0]         bg_x_offset_o,
    output logic               gap_valid_o,
    output logic [7:0]         gap_x_o,
    output logic               scroll_step_o,
    output logic               frame_done_o
);

    localparam int DLY_W  = $clog2(SCROLL_DELAY_MAX + 1);
    localparam int WAIT_W = $clog2(3 * WAIT_UNIT + 1);
    localparam int CC_W   = $clog2(SPEEDUP_COLS + 1);
    localparam int COL_W  = $clog2(TILE_COLS + 1);
    localparam int ROW_W  = $clog2(FLOOR_ROWS + 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DRAW = 2'd1, S_DONE = 2'd2} state_t;

    state_t             state_q, state_d;
    logic [DLY_W-1:0]   scroll_cnt_q, scroll_cnt_d;
    logic [DLY_W-1:0]   scroll_delay_q, scroll_delay_d;
    logic [3:0]         fine_q, fine_d;
    logic               scroll_step_q, scroll_step_d;
    logic [CC_W-1:0]    coarse_cnt_q, coarse_cnt_d;
    logic               gap_valid_q, gap_valid_d;
    logic [7:0]         gap_x_q, gap_x_d;
    logic [WAIT_W-1:0]  wait_timer_q, wait_timer_d;
    logic [3:0]         lfsr_q, lfsr_d;
    logic               pending_q, pending_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [7:0]         sw_gap_x_q, sw_gap_x_d;
    logic               sw_gap_valid_q, sw_gap_valid_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [15:0]        data_q, data_d;
    logic               frame_done_q, frame_done_d;
    logic               coarse_step;
    logic [WAIT_W-1:0]  wait_load;

    // Tile word for floor row r, column c against the gap latched for the sweep.
    function automatic logic [15:0] tile_word(input int r, input int c, input int g, input logic v);
        logic [15:0] w;
        if (!v)
            w = (r == 0) ? 16'h130 : 16'h133;
        else if (c >= g && c < g + GAP_W)
            w = 16'h000;
        else if (g > 0 && c == g - 1)
            w = (r == 0) ? 16'h131 : 16'h138;
        else if (c == g + GAP_W)
            w = (r == 0) ? 16'h171 : 16'h178;
        else
            w = (r == 0) ? 16'h130 : 16'h133;
        return w;
    endfunction

    always_comb begin
        case (lfsr_q[1:0])
            2'd1:    wait_load = WAIT_W'(2 * WAIT_UNIT);
            2'd2:    wait_load = WAIT_W'(3 * WAIT_UNIT);
            default: wait_load = WAIT_W'(WAIT_UNIT);
        endcase
    end

    always_comb begin
        state_d        = state_q;
        scroll_cnt_d   = scroll_cnt_q;
        scroll_delay_d = scroll_delay_q;
        fine_d         = fine_q;
        scroll_step_d  = 1'b0;
        coarse_cnt_d   = coarse_cnt_q;
        gap_valid_d    = gap_valid_q;
        gap_x_d        = gap_x_q;
        wait_timer_d   = wait_timer_q;
        lfsr_d         = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
        pending_d      = pending_q;
        row_d          = row_q;
        col_d          = col_q;
        sw_gap_x_d     = sw_gap_x_q;
        sw_gap_valid_d = sw_gap_valid_q;
        we_d           = 1'b0;
        addr_d         = addr_q;
        data_d         = data_q;
        frame_done_d   = 1'b0;
        coarse_step    = 1'b0;

        if (enable_i) begin
            if (scroll_cnt_q == scroll_delay_q) begin
                scroll_cnt_d  = '0;
                scroll_step_d = 1'b1;
                fine_d        = fine_q + 4'd1;
                coarse_step   = (fine_q == 4'hF);
            end else begin
                scroll_cnt_d = scroll_cnt_q + DLY_W'(1);
            end

            if (!gap_valid_q && wait_timer_q != '0)
                wait_timer_d = wait_timer_q - WAIT_W'(1);

            case (state_q)
                S_IDLE: begin
                    if (pending_q) begin
                        state_d        = S_DRAW;
                        pending_d      = 1'b0;
                        sw_gap_x_d     = gap_x_q;
                        sw_gap_valid_d = gap_valid_q;
                        row_d          = '0;
                        col_d          = '0;
                    end
                end
                S_DRAW: begin
                    if (we_q && bg_if.bg_ready) begin
                        if (col_q == COL_W'(TILE_COLS - 1)) begin
                            col_d = '0;
                            if (row_q == ROW_W'(FLOOR_ROWS - 1))
                                state_d = S_DONE;
                            else
                                row_d = row_q + ROW_W'(1);
                        end else begin
                            col_d = col_q + COL_W'(1);
                        end
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase

            // A coarse step during a sweep leaves the request pending for the next one.
            if (coarse_step) begin
                pending_d = 1'b1;
                if (gap_valid_q) begin
                    if (gap_x_q != 8'd0) begin
                        gap_x_d = gap_x_q - 8'd1;
                    end else begin
                        gap_valid_d  = 1'b0;
                        wait_timer_d = wait_load;
                    end
                end else if (wait_timer_q == '0) begin
                    gap_valid_d = 1'b1;
                    gap_x_d     = 8'(TILE_COLS - 1);
                end

                if (int'(coarse_cnt_q) >= SPEEDUP_COLS - 1) begin
                    coarse_cnt_d = '0;
                    if (int'(scroll_delay_q) >= SCROLL_DELAY_MIN + SPEED_STEP)
                        scroll_delay_d = DLY_W'(int'(scroll_delay_q) - SPEED_STEP);
                    else
                        scroll_delay_d = DLY_W'(SCROLL_DELAY_MIN);
                end else begin
                    coarse_cnt_d = coarse_cnt_q + CC_W'(1);
                end
            end

            we_d         = (state_d == S_DRAW);
            frame_done_d = (state_d == S_DONE);
            if (state_d == S_DRAW) begin
                addr_d = ADDR_W'(int'(col_d) + (TILE_ROWS - FLOOR_ROWS + int'(row_d)) * TILE_COLS);
                data_d = tile_word(int'(row_d), int'(col_d), int'(sw_gap_x_d), sw_gap_valid_d);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            scroll_cnt_q   <= '0;
            scroll_delay_q <= DLY_W'(SCROLL_DELAY_MAX);
            fine_q         <= 4'd0;
            scroll_step_q  <= 1'b0;
            coarse_cnt_q   <= '0;
            gap_valid_q    <= 1'b1;
            gap_x_q        <= 8'(GAP_START_COL);
            wait_timer_q   <= '0;
            lfsr_q         <= 4'b1011;
            pending_q      <= 1'b1;
            row_q          <= '0;
            col_q          <= '0;
            sw_gap_x_q     <= 8'd0;
            sw_gap_valid_q <= 1'b0;
            we_q           <= 1'b0;
            addr_q         <= '0;
            data_q         <= 16'd0;
            frame_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            scroll_cnt_q   <= scroll_cnt_d;
            scroll_delay_q <= scroll_delay_d;
            fine_q         <= fine_d;
            scroll_step_q  <= scroll_step_d;
            coarse_cnt_q   <= coarse_cnt_d;
            gap_valid_q    <= gap_valid_d;
            gap_x_q        <= gap_x_d;
            wait_timer_q   <= wait_timer_d;
            lfsr_q         <= lfsr_d;
            pending_q      <= pending_d;
            row_q          <= row_d;
            col_q          <= col_d;
            sw_gap_x_q     <= sw_gap_x_d;
            sw_gap_valid_q <= sw_gap_valid_d;
            we_q           <= we_d;
            addr_q         <= addr_d;
            data_q         <= data_d;
            frame_done_q   <= frame_done_d;
        end
    end

`ifdef HUD_LOCK_EN
    logic [3:0] hud_off_q;
    always_ff @(posedge clk) begin
        if (reset)
            hud_off_q <= 4'd0;
        else
            hud_off_q <= (int'(y_i) < HUD_H) ? 4'd0 : fine_q;
    end
    assign bg_x_offset_o = hud_off_q;
`else
    assign bg_x_offset_o = fine_q;
`endif

    // Registered valid is masked by enable so a frozen sweep never completes a handshake.
    assign bg_if.bg_we   = we_q & enable_i;
    assign bg_if.bg_addr = addr_q;
    assign bg_if.bg_data = data_q;
    assign gap_valid_o   = gap_valid_q;
    assign gap_x_o       = gap_x_q;
    assign scroll_step_o = scroll_step_q;
    assign frame_done_o  = frame_done_q;

endmodule

`default_nettype wire
